// File: rtl/eab_arbiter.sv
// Two-port round-robin arbiter in front of an EAB with a registered address and a registered output.
// Read responses are tracked by a two-stage {valid, port} pipeline that matches the RAM read latency.
module eab_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [WIDTH-1:0]      p0_wdata,
    output logic                  p0_rvalid,
    output logic [WIDTH-1:0]      p0_rdata,

    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [WIDTH-1:0]      p1_wdata,
    output logic                  p1_rvalid,
    output logic [WIDTH-1:0]      p1_rdata,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [WIDTH-1:0]      ram_data,
    input  logic [WIDTH-1:0]      ram_q
);

    logic                  rr;
    logic                  grant0;
    logic                  grant1;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [WIDTH-1:0]      data_hold;
    logic                  s1_valid;
    logic                  s1_port;
    logic                  s2_valid;
    logic                  s2_port;

    // rr names the port that wins when both are valid.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (p0_valid && (!p1_valid || !rr)) begin
                grant0 = 1'b1;
            end else if (p1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign p0_ready = grant0;
    assign p1_ready = grant1;

    // Idle cycles keep presenting the last granted address/data to the EAB.
    always_comb begin
        ram_we      = 1'b0;
        ram_address = addr_hold;
        ram_data    = data_hold;
        if (rst) begin
            ram_address = '0;
            ram_data    = '0;
        end else if (grant0) begin
            ram_we      = p0_we;
            ram_address = p0_addr;
            ram_data    = p0_wdata;
        end else if (grant1) begin
            ram_we      = p1_we;
            ram_address = p1_addr;
            ram_data    = p1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr        <= 1'b0;
            addr_hold <= '0;
            data_hold <= '0;
            s1_valid  <= 1'b0;
            s1_port   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_port   <= 1'b0;
        end else begin
            if (grant0 || grant1) begin
                rr        <= grant0;
                addr_hold <= ram_address;
                data_hold <= ram_data;
            end
            s1_valid <= (grant0 && !p0_we) || (grant1 && !p1_we);
            s1_port  <= grant1;
            s2_valid <= s1_valid;
            s2_port  <= s1_port;
        end
    end

    assign p0_rvalid = !rst && s2_valid && !s2_port;
    assign p1_rvalid = !rst && s2_valid && s2_port;
    assign p0_rdata  = p0_rvalid ? ram_q : '0;
    assign p1_rdata  = p1_rvalid ? ram_q : '0;

endmodule

// File: doc/eab_arbiter.md
EAB_ARBITER -- requirements
Module: eab_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, data word width in bits.
REQ-002 Parameter: ADDR_WIDTH, default 8, word-address width; RAM depth is 2**ADDR_WIDTH.
REQ-003 Port: clk  input  1  single clock; drives the EAB inclock and outclock externally.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: p0_valid  input  1  requester 0 (load/store) has a request.
REQ-006 Port: p0_ready  output  1  request 0 accepted this cycle.
REQ-007 Port: p0_we  input  1  request 0 is a write (1) or read (0).
REQ-008 Port: p0_addr  input  ADDR_WIDTH  request 0 word address.
REQ-009 Port: p0_wdata  input  WIDTH  request 0 write data.
REQ-010 Port: p0_rvalid  output  1  read response for requester 0 this cycle.
REQ-011 Port: p0_rdata  output  WIDTH  requester 0 read data; valid only while p0_rvalid.
REQ-012 Ports p1_valid, p1_ready, p1_we, p1_addr, p1_wdata, p1_rvalid, p1_rdata SHALL mirror REQ-005..011 for requester 1 (instruction fetch).
REQ-013 Port: ram_we  output  1  EAB write enable.
REQ-014 Port: ram_address  output  ADDR_WIDTH  EAB address.
REQ-015 Port: ram_data  output  WIDTH  EAB write data.
REQ-016 Port: ram_q  input  WIDTH  EAB read data, two-edge latency.

Function
REQ-017 Handshake: a request transfers in a cycle where pN_valid=1 and pN_ready=1; a requester SHALL hold valid, we, addr and wdata stable until the transfer occurs.
REQ-018 At most one of p0_ready/p1_ready SHALL be high per cycle; readiness is combinational from the valid inputs and the priority pointer.
REQ-019 Arbitration: when only one port is valid, that port is granted; when both are valid, the port indicated by the 1-bit pointer rr is granted.
REQ-020 After each granted transfer, rr SHALL point to the other port, giving round-robin fairness; rr is unchanged in idle cycles.
REQ-021 During a grant, ram_address, ram_data and ram_we SHALL equal the granted port's addr, wdata and we.
REQ-022 In idle cycles, ram_we=0, and ram_address and ram_data SHALL hold their previous values.
REQ-023 Read latency: a read accepted in cycle N SHALL return pN_rvalid=1 for exactly one cycle in cycle N+2, with pN_rdata=ram_q.
REQ-024 Tracking: a 2-stage shift pipeline SHALL carry {valid, port_id} for each accepted read; writes enter as invalid.
REQ-025 Throughput: one transfer per cycle SHALL be sustained, with back-to-back reads from either or both ports and no bubbles.
REQ-026 p0_rvalid and p1_rvalid SHALL never be high in the same cycle.
REQ-027 The pN_rdata of the non-responding port SHALL be 0.
REQ-028 Writes SHALL produce no response.
REQ-029 A write accepted in cycle N SHALL be visible to a read accepted in cycle N+1 or later.
REQ-030 Responses SHALL return in acceptance order.
REQ-031 Requesters have no response backpressure; a response is presented once and is not stored.

Reset
REQ-032 While rst=1, the block SHALL drive: p0_ready=p1_ready=0, ram_we=0, ram_address=0, ram_data=0, and both pipeline stages invalid.
REQ-033 While rst=1, rr SHALL be set to 0 (port 0 first).
REQ-034 Outputs in the cycle after rst deasserts: p0_rvalid=p1_rvalid=0.
REQ-035 Reset mid-operation SHALL discard all in-flight reads; no rvalid is issued for them.
REQ-036 RAM contents are not affected by reset.

Verification
REQ-037 Single read: after reset, p0 reads addr 0x05 (preloaded 0xDEADBEEF) in cycle 10 -> p0_rvalid=1 and p0_rdata=0xDEADBEEF in cycle 12 only.
REQ-038 Contention: p0 and p1 both hold valid reads (0x01, 0x02) from cycle 5 -> p0 granted in cycle 5 and p1 in cycle 6; responses are p0 in cycle 7 and p1 in cycle 8.
REQ-039 Round-robin: both ports continuously request for 8 cycles -> grants alternate 0,1,0,1,...; each port receives 4 grants.
REQ-040 Write-then-read: p0 writes 0x12345678 to 0x10 in cycle N, p1 reads 0x10 in cycle N+1 -> p1_rdata=0x12345678 in cycle N+3; no rvalid for the write.
REQ-041 Reset mid-flight: p1 read accepted in cycle N, rst=1 in cycle N+1 -> no p1_rvalid in cycles N+2..N+4; after reset, rr=0.
REQ-042 Streaming: p1 issues 16 back-to-back reads of addr 0..15 -> 16 consecutive rvalid cycles with data in address order; p1_ready stays high throughout.
